// File: rtl/seven_seg_ascii_scroller.sv
// Seven-segment ASCII scroller: buffers an incoming ASCII byte stream in a
// small FIFO and shifts one character per scroll tick into a character array
// that feeds the ASCII display wrapper. Display 0 is the rightmost display,
// so text enters on the right and scrolls right-to-left.
module seven_seg_ascii_scroller #(
  parameter int DISPLAY_COUNT = 4,
  parameter int SOURCE_FREQ   = 100_000_000,
  parameter int SCROLL_HZ     = 4,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 char_in,
  input  logic                       char_valid,
  output logic                       char_ready,
  input  logic                       clear,
  input  logic                       pad,
  output logic [8*DISPLAY_COUNT-1:0] values,
  output logic [DISPLAY_COUNT-1:0]   display_enable,
  output logic                       idle
);

  localparam int TICK_DIV = SOURCE_FREQ / SCROLL_HZ;
  localparam int TW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int AW       = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW       = AW + 1;
  localparam int VW       = 8 * DISPLAY_COUNT;

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DEPTH_FULL = CW'(FIFO_DEPTH);
  localparam logic [7:0]    SPACE      = 8'h20;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [TW-1:0] tick_cnt;

  logic          tick;
  logic          push;
  logic          pop;
  logic          shift_en;
  logic [7:0]    head;
  logic [7:0]    shift_char;
  logic [VW-1:0] values_next;
  logic [DISPLAY_COUNT-1:0] enable_next;

  // Handshake, tick and pop decisions, all from registered state.
  always_comb begin
    char_ready = (count != DEPTH_FULL);
    idle       = (count == '0);
    tick       = (tick_cnt == TICK_LAST);
    push       = char_valid && char_ready && !reset && !clear;
    // A push on the tick cycle is not yet in count, so it cannot be popped
    // by this tick; it waits for the next one.
    pop        = tick && (count != '0);
    head       = fifo_mem[rd_ptr];
  end

  // Next character array: shift in the FIFO head, a pad space, or hold.
  always_comb begin
    shift_en    = 1'b0;
    shift_char  = SPACE;
    values_next = values;
    if (pop) begin
      shift_en   = 1'b1;
      shift_char = head;
    end else if (tick && pad) begin
      shift_en   = 1'b1;
      shift_char = SPACE;
    end
    if (shift_en) begin
      values_next = (values << 8) | VW'(shift_char);
    end
  end

  // Enables are derived from the next array so they never lag values.
  always_comb begin
    enable_next = '0;
    for (int i = 0; i < DISPLAY_COUNT; i++) begin
      enable_next[i] = (values_next[8*i +: 8] != SPACE);
    end
  end

  // Scroll tick counter: 0..TICK_DIV-1, restarted by reset or clear.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= char_in;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at a power of two.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Character array and display enables, blanked by reset or clear.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      values         <= {DISPLAY_COUNT{SPACE}};
      display_enable <= '0;
    end else begin
      values         <= values_next;
      display_enable <= enable_next;
    end
  end

endmodule

// File: tb/tb_seven_seg_ascii_scroller.sv
// Directed bench for seven_seg_ascii_scroller with TICK_DIV=4, FIFO_DEPTH=4.
module tb_seven_seg_ascii_scroller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  char_in = 8'h00;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic        clear = 1'b0;
  logic        pad = 1'b0;
  logic [31:0] values;
  logic [3:0]  display_enable;
  logic        idle;

  int total = 0;
  int bad = 0;

  seven_seg_ascii_scroller #(
    .DISPLAY_COUNT(4),
    .SOURCE_FREQ(8),
    .SCROLL_HZ(2),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .char_in(char_in),
    .char_valid(char_valid),
    .char_ready(char_ready),
    .clear(clear),
    .pad(pad),
    .values(values),
    .display_enable(display_enable),
    .idle(idle)
  );

  always #5 clk = ~clk;

  // One rising edge, then settle before anything is sampled or driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    char_valid = 1'b1;
    char_in = 8'h58;
    clear = 1'b0;
    pad = 1'b0;
    step();
    step();
    reset = 1'b0;
    char_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({values, display_enable, idle, char_ready} !== {32'h20202020, 4'b0000, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL reset_state: got values=%h en=%b idle=%b rdy=%b, want 20202020 0000 1 1",
               values, display_enable, idle, char_ready);
    end
    // Four edges include one empty tick with pad=0: nothing may appear.
    for (int i = 0; i < 4; i++) step();
    total++;
    if ({values, display_enable, idle} !== {32'h20202020, 4'b0000, 1'b1}) begin
      bad++;
      $display("FAIL reset_fifo_empty: got values=%h en=%b idle=%b, want 20202020 0000 1",
               values, display_enable, idle);
    end
  endtask

  task automatic test_hola_scroll();
    logic [31:0] str;
    str = 32'h484F4C41;
    do_reset();
    for (int i = 3; i >= 0; i--) begin
      char_in = str[8*i +: 8];
      char_valid = 1'b1;
      step();
    end
    char_valid = 1'b0;
    // Edge 4 was the first tick: 'H' popped while 'A' was pushed.
    total++;
    if ({values, display_enable, idle} !== {32'h20202048, 4'b0001, 1'b0}) begin
      bad++;
      $display("FAIL hola_tick1: got values=%h en=%b idle=%b, want 20202048 0001 0",
               values, display_enable, idle);
    end
    for (int i = 0; i < 4; i++) step();
    total++;
    if ({values, display_enable} !== {32'h2020484F, 4'b0011}) begin
      bad++;
      $display("FAIL hola_tick2: got values=%h en=%b, want 2020484F 0011", values, display_enable);
    end
    for (int i = 0; i < 8; i++) step();
    total++;
    if ({values, display_enable, idle} !== {32'h484F4C41, 4'b1111, 1'b1}) begin
      bad++;
      $display("FAIL hola_tick4: got values=%h en=%b idle=%b, want 484F4C41 1111 1",
               values, display_enable, idle);
    end
    for (int i = 0; i < 8; i++) step();
    total++;
    if ({values, display_enable, idle} !== {32'h484F4C41, 4'b1111, 1'b1}) begin
      bad++;
      $display("FAIL hola_hold: got values=%h en=%b idle=%b, want 484F4C41 1111 1",
               values, display_enable, idle);
    end
  endtask

  // Runs directly after test_hola_scroll, keeping its tick phase.
  task automatic test_pad_scroll_out();
    logic [31:0] exp_v [4];
    logic [3:0]  exp_e [4];
    exp_v = '{32'h4F4C4120, 32'h4C412020, 32'h41202020, 32'h20202020};
    exp_e = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
    pad = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) step();
      total++;
      if ({values, display_enable} !== {exp_v[k], exp_e[k]}) begin
        bad++;
        $display("FAIL pad_step%0d: got values=%h en=%b, want %h %b",
                 k, values, display_enable, exp_v[k], exp_e[k]);
      end
    end
    pad = 1'b0;
  endtask

  task automatic test_backpressure();
    int idx;
    logic rdy;
    logic [31:0] exp_v;
    int k;
    do_reset();
    for (int i = 0; i < 3; i++) step();
    idx = 0;
    k = 0;
    exp_v = 32'h20202020;
    char_valid = 1'b1;
    for (int e = 4; e <= 32; e++) begin
      char_in = 8'h41 + 8'(idx);
      rdy = char_ready;
      step();
      if (rdy && char_valid) idx++;
      if (idx == 6) char_valid = 1'b0;
      if (e == 4) begin
        total++;
        if ({values, idle} !== {32'h20202020, 1'b0}) begin
          bad++;
          $display("FAIL bp_push_on_tick: got values=%h idle=%b, want 20202020 0", values, idle);
        end
      end
      if (e == 7) begin
        total++;
        if ({char_ready, 3'(idx)} !== {1'b0, 3'd4}) begin
          bad++;
          $display("FAIL bp_full: got rdy=%b accepted=%0d, want 0 4", char_ready, idx);
        end
      end
      if (e == 8) begin
        total++;
        if ({char_ready, 3'(idx)} !== {1'b1, 3'd4}) begin
          bad++;
          $display("FAIL bp_after_pop: got rdy=%b accepted=%0d, want 1 4", char_ready, idx);
        end
      end
      if (e == 9) begin
        total++;
        if ({char_ready, 3'(idx)} !== {1'b0, 3'd5}) begin
          bad++;
          $display("FAIL bp_e_accepted: got rdy=%b accepted=%0d, want 0 5", char_ready, idx);
        end
      end
      if ((e % 4 == 0) && e >= 8 && e <= 28) begin
        exp_v = {exp_v[23:0], 8'h41 + 8'(k)};
        k++;
        total++;
        if (values !== exp_v) begin
          bad++;
          $display("FAIL bp_tick%0d: got values=%h, want %h", k, values, exp_v);
        end
      end
    end
    char_valid = 1'b0;
    total++;
    if ({values, idle, 3'(idx)} !== {32'h43444546, 1'b1, 3'd6}) begin
      bad++;
      $display("FAIL bp_final: got values=%h idle=%b accepted=%0d, want 43444546 1 6",
               values, idle, idx);
    end
  endtask

  task automatic test_clear();
    logic [31:0] str;
    str = 32'h48494A4B;
    do_reset();
    for (int i = 3; i >= 0; i--) begin
      char_in = str[8*i +: 8];
      char_valid = 1'b1;
      step();
    end
    char_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    total++;
    if ({values, idle} !== {32'h20204849, 1'b0}) begin
      bad++;
      $display("FAIL clear_setup: got values=%h idle=%b, want 20204849 0", values, idle);
    end
    clear = 1'b1;
    char_valid = 1'b1;
    char_in = 8'h51;
    step();
    clear = 1'b0;
    char_valid = 1'b0;
    total++;
    if ({values, display_enable, idle, char_ready} !== {32'h20202020, 4'b0000, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL clear_state: got values=%h en=%b idle=%b rdy=%b, want 20202020 0000 1 1",
               values, display_enable, idle, char_ready);
    end
    char_in = 8'h5A;
    char_valid = 1'b1;
    step();
    char_valid = 1'b0;
    step();
    step();
    total++;
    if ({values, idle} !== {32'h20202020, 1'b0}) begin
      bad++;
      $display("FAIL clear_pre_tick: got values=%h idle=%b, want 20202020 0", values, idle);
    end
    step();
    total++;
    if ({values, display_enable, idle} !== {32'h2020205A, 4'b0001, 1'b1}) begin
      bad++;
      $display("FAIL clear_first_tick: got values=%h en=%b idle=%b, want 2020205A 0001 1",
               values, display_enable, idle);
    end
  endtask

  task automatic test_push_on_tick();
    do_reset();
    for (int i = 0; i < 3; i++) step();
    char_in = 8'h5A;
    char_valid = 1'b1;
    step();
    char_valid = 1'b0;
    total++;
    if ({values, idle} !== {32'h20202020, 1'b0}) begin
      bad++;
      $display("FAIL pot_same_edge: got values=%h idle=%b, want 20202020 0", values, idle);
    end
    for (int i = 0; i < 3; i++) step();
    total++;
    if (values !== 32'h20202020) begin
      bad++;
      $display("FAIL pot_before_next: got values=%h, want 20202020", values);
    end
    step();
    total++;
    if ({values, display_enable, idle} !== {32'h2020205A, 4'b0001, 1'b1}) begin
      bad++;
      $display("FAIL pot_next_tick: got values=%h en=%b idle=%b, want 2020205A 0001 1",
               values, display_enable, idle);
    end
  endtask

  initial begin
    test_reset();
    test_hola_scroll();
    test_pad_scroll_out();
    test_backpressure();
    test_clear();
    test_push_on_tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
